// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the 4-bit CPU control unit: widths, opcodes, ALU codes,
// FSM state encoding and the decoded control word.
package cpu_control_fsm_pkg;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 4;
    localparam int unsigned INSTR_W = OP_W + IMM_W;
    localparam int unsigned ALU_W   = 3;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_LDB = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB = 4'h4;
    localparam logic [OP_W-1:0] OP_AND = 4'h5;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR = 4'h7;
    localparam logic [OP_W-1:0] OP_NOT = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP = 4'hA;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hB;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // Shared with the datapath ALU.
    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_W-1:0] ALU_NOT = 3'd5;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    typedef struct packed {
        logic             a_we;
        logic             b_we;
        logic             out_we;
        logic             load_sel;
        logic             is_alu;
        logic [ALU_W-1:0] alu_op;
        logic             is_jmp;
        logic             is_jz;
        logic             is_hlt;
        logic             is_illegal;
    } ctrl_t;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control-unit boundary: ROM fetch port plus the control signals to the datapath.
interface cpu_control_fsm_if;
    import cpu_control_fsm_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               zero_flag;
    logic [PC_W-1:0]    pc;
    logic [IMM_W-1:0]   imm;
    logic               load_sel;
    logic [ALU_W-1:0]   alu_op;
    logic               a_we;
    logic               b_we;
    logic               out_we;
    logic               halted;
    logic               illegal;

    modport master (
        input  instr, zero_flag,
        output pc, imm, load_sel, alu_op, a_we, b_we, out_we, halted, illegal
    );

    modport slave (
        output instr, zero_flag,
        input  pc, imm, load_sel, alu_op, a_we, b_we, out_we, halted, illegal
    );
endinterface

// File: rtl/cpu_control_fsm_op_decoder.sv
// Combinational opcode decoder producing the control word for one instruction.
module cpu_control_fsm_op_decoder
    import cpu_control_fsm_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (op_i)
            OP_NOP: ;
            OP_LDA: begin
                ctrl_o.a_we     = 1'b1;
                ctrl_o.load_sel = 1'b1;
            end
            OP_LDB: begin
                ctrl_o.b_we     = 1'b1;
                ctrl_o.load_sel = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                ctrl_o.a_we   = 1'b1;
                ctrl_o.is_alu = 1'b1;
                // ALU codes are contiguous and start at ADD.
                ctrl_o.alu_op = ALU_ADD + ALU_W'(op_i - OP_ADD);
            end
            OP_OUT: ctrl_o.out_we = 1'b1;
            OP_JMP: ctrl_o.is_jmp = 1'b1;
            OP_JZ:  ctrl_o.is_jz  = 1'b1;
            OP_HLT: ctrl_o.is_hlt = 1'b1;
            default: ctrl_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction, all outputs registered,
// enables valid only in EXECUTE, PC updated at the end of EXECUTE.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    cpu_control_fsm_if.master  bus
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ALU_W-1:0]   alu_op_q, alu_op_d;
    logic               a_we_q, a_we_d;
    logic               b_we_q, b_we_d;
    logic               out_we_q, out_we_d;
    logic               load_sel_q, load_sel_d;
    logic               illegal_q, illegal_d;
    logic               halted_q, halted_d;
    logic               jmp_q, jmp_d;
    logic               jz_q, jz_d;
    logic               hlt_q, hlt_d;
    ctrl_t              dec;

    cpu_control_fsm_op_decoder u_op_decoder (
        .op_i   (ir_q[INSTR_W-1:IMM_W]),
        .ctrl_o (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            alu_op_q   <= '0;
            a_we_q     <= 1'b0;
            b_we_q     <= 1'b0;
            out_we_q   <= 1'b0;
            load_sel_q <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
            jmp_q      <= 1'b0;
            jz_q       <= 1'b0;
            hlt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            alu_op_q   <= alu_op_d;
            a_we_q     <= a_we_d;
            b_we_q     <= b_we_d;
            out_we_q   <= out_we_d;
            load_sel_q <= load_sel_d;
            illegal_q  <= illegal_d;
            halted_q   <= halted_d;
            jmp_q      <= jmp_d;
            jz_q       <= jz_d;
            hlt_q      <= hlt_d;
        end
    end

    // Enables default to 0 so they are high for exactly the EXECUTE cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        alu_op_d   = alu_op_q;
        a_we_d     = 1'b0;
        b_we_d     = 1'b0;
        out_we_d   = 1'b0;
        load_sel_d = 1'b0;
        illegal_d  = 1'b0;
        halted_d   = halted_q;
        jmp_d      = jmp_q;
        jz_d       = jz_q;
        hlt_d      = hlt_q;

        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d    = bus.instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_we_d     = dec.a_we;
                b_we_d     = dec.b_we;
                out_we_d   = dec.out_we;
                load_sel_d = dec.load_sel;
                illegal_d  = dec.is_illegal;
                jmp_d      = dec.is_jmp;
                jz_d       = dec.is_jz;
                hlt_d      = dec.is_hlt;
                if (dec.is_alu) begin
                    alu_op_d = dec.alu_op;
                end
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (hlt_q) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    if (jmp_q || (jz_q && bus.zero_flag)) begin
                        pc_d = PC_W'(ir_q[IMM_W-1:0]);
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.imm      = ir_q[IMM_W-1:0];
    assign bus.load_sel = load_sel_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.a_we     = a_we_q;
    assign bus.b_we     = b_we_q;
    assign bus.out_we   = out_we_q;
    assign bus.halted   = halted_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm; outputs sampled on the falling edge.
module tb_cpu_control_fsm;

    logic clk;
    logic reset;
    logic run;
    int   n_checks;
    int   n_pass;
    int   bad;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // {load_sel, a_we, b_we, out_we}
    function automatic logic [31:0] ens();
        return 32'({bus.load_sel, bus.a_we, bus.b_we, bus.out_we});
    endfunction

    function automatic logic [31:0] st();
        return 32'(dut.state_q);
    endfunction

    // From a FETCH cycle with run=1, present ins and advance to its EXECUTE cycle.
    task automatic exec_to(input logic [7:0] ins);
        bus.instr = ins;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        run           = 1'b1;
        bus.instr     = 8'h17;
        bus.zero_flag = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_imm", 32'(bus.imm), 32'd0);
        chk("rst_en", ens(), 32'd0);
        chk("rst_alu", 32'(bus.alu_op), 32'd0);
        chk("rst_flags", 32'({bus.halted, bus.illegal}), 32'd0);
        chk("rst_state", st(), 32'd0);

        // LDA 7 straight out of reset
        reset = 1'b0;
        chk("lda7_c1_state", st(), 32'd0);
        @(negedge clk);
        chk("lda7_c2_state", st(), 32'd1);
        chk("lda7_c2_en", ens(), 32'd0);
        @(negedge clk);
        chk("lda7_c3_state", st(), 32'd2);
        chk("lda7_c3_en", ens(), 32'b1100);
        chk("lda7_c3_imm", 32'(bus.imm), 32'd7);
        chk("lda7_c3_pc", 32'(bus.pc), 32'd0);
        @(negedge clk);
        chk("lda7_pc", 32'(bus.pc), 32'd1);
        chk("lda7_after_en", ens(), 32'd0);
        chk("lda7_after_state", st(), 32'd0);

        // Program: LDA 3, LDB 5, ADD, OUT, NOT
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exec_to(8'h13);
        chk("lda3_en", ens(), 32'b1100);
        chk("lda3_imm", 32'(bus.imm), 32'd3);
        @(negedge clk);
        exec_to(8'h25);
        chk("ldb5_en", ens(), 32'b1010);
        chk("ldb5_imm", 32'(bus.imm), 32'd5);
        @(negedge clk);
        exec_to(8'h30);
        chk("add_en", ens(), 32'b0100);
        chk("add_alu", 32'(bus.alu_op), 32'd0);
        @(negedge clk);
        exec_to(8'h90);
        chk("out_en", ens(), 32'b0001);
        @(negedge clk);
        chk("prog_pc", 32'(bus.pc), 32'd4);
        exec_to(8'h80);
        chk("not_en", ens(), 32'b0100);
        chk("not_alu", 32'(bus.alu_op), 32'd5);
        @(negedge clk);
        chk("not_pc", 32'(bus.pc), 32'd5);

        // Branches and PC wrap
        bus.zero_flag = 1'b0;
        exec_to(8'hB9);
        @(negedge clk);
        chk("jz_not_taken_pc", 32'(bus.pc), 32'd6);
        bus.zero_flag = 1'b1;
        exec_to(8'hBA);
        @(negedge clk);
        chk("jz_taken_pc", 32'(bus.pc), 32'hA);
        bus.zero_flag = 1'b0;
        exec_to(8'hAF);
        chk("jmp_en", ens(), 32'd0);
        @(negedge clk);
        chk("jmp_f_pc", 32'(bus.pc), 32'hF);
        exec_to(8'h00);
        chk("nop_en", ens(), 32'd0);
        chk("nop_alu_hold", 32'(bus.alu_op), 32'd5);
        @(negedge clk);
        chk("wrap_pc", 32'(bus.pc), 32'd0);
        exec_to(8'hAF);
        @(negedge clk);
        exec_to(8'hA2);
        @(negedge clk);
        chk("jmp_from_f_pc", 32'(bus.pc), 32'd2);

        // Undefined opcode
        exec_to(8'hC0);
        chk("ill_pulse", 32'(bus.illegal), 32'd1);
        chk("ill_en", ens(), 32'd0);
        @(negedge clk);
        chk("ill_clear", 32'(bus.illegal), 32'd0);
        chk("ill_pc", 32'(bus.pc), 32'd3);

        // HALT at pc 3
        exec_to(8'hF0);
        chk("hlt_exec_halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        chk("hlt_halted", 32'(bus.halted), 32'd1);
        chk("hlt_pc", 32'(bus.pc), 32'd3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.halted !== 1'b1 || bus.pc !== 4'd3 || ens() !== 32'd0) bad++;
        end
        chk("hlt_hold_20", 32'(bad), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("hlt_rst_halted", 32'(bus.halted), 32'd0);
        chk("hlt_rst_pc", 32'(bus.pc), 32'd0);

        // run gating
        run       = 1'b0;
        bus.instr = 8'h12;
        repeat (5) @(negedge clk);
        chk("run0_state", st(), 32'd0);
        chk("run0_pc", 32'(bus.pc), 32'd0);
        chk("run0_en", ens(), 32'd0);
        run = 1'b1;
        @(negedge clk);
        chk("run1_decode", st(), 32'd1);
        run = 1'b0;
        @(negedge clk);
        chk("rundrop_exec_en", ens(), 32'b1100);
        chk("rundrop_exec_imm", 32'(bus.imm), 32'd2);
        @(negedge clk);
        chk("rundrop_pc", 32'(bus.pc), 32'd1);
        @(negedge clk);
        chk("rundrop_stall", st(), 32'd0);
        chk("rundrop_stall_pc", 32'(bus.pc), 32'd1);

        // Reset in the middle of an ADD EXECUTE
        run = 1'b1;
        exec_to(8'h30);
        chk("midrst_exec_en", ens(), 32'b0100);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_en", ens(), 32'd0);
        chk("midrst_state", st(), 32'd0);
        chk("midrst_pc", 32'(bus.pc), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
